// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared encodings for the IF/MEM memory-port arbiter.
//   arbStateT : FSM state encoding (IDLE, BUSY, RESP)
//   arbGrantT : current owner of the memory port (none, fetch, data)
//   STARVE_LIMIT_DEFAULT : default data-grant budget while fetch waits
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arbStateT;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } arbGrantT;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch requester, data requester and
// memory handshake signals of the shared memory port.
//   slave  : arbiter view (takes requests and memory response, drives
//            acks, read data and the memory command)
//   master : environment view (requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// mem_arb_starve_ctr: counts data grants issued while fetch is waiting,
// saturating at STARVE_LIMIT. Once saturated, 'override' tells the arbiter
// to hand the next contested slot to fetch. Any fetch grant clears it.
//   clk, rst_n   : clock, asynchronous active-low reset
//   dGrantWhileI : a data grant is being made while if_req is high
//   iGrant       : a fetch grant is being made
//   override     : budget exhausted, fetch wins the next collision
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dGrantWhileI,
  input  logic iGrant,
  output logic override
);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (iGrant) begin
      count <= '0;
    end else if (dGrantWhileI && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign override = (count == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory
// between the fetch stage and the memory stage. Requests are serialised
// through an IDLE -> BUSY -> RESP sequence; each requester receives a
// one-cycle ack with its read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (requests, acks, memory port)
//   stall_f    : if_req & ~if_ack
//   stall_m    : d_req & ~d_ack
//   busy       : FSM not in IDLE
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT data
// grants made while fetch waits, fetch wins the next collision. Without
// it data always has priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          AW           = 32,
  parameter int          DW           = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic                 stall_f,
  output logic                 stall_m,
  output logic                 busy
);

  if (STARVE_LIMIT < 1) begin : gCheckLimit
    $error("STARVE_LIMIT must be at least 1");
  end

  arbStateT      state, stateNext;
  arbGrantT      grant, grantNext;
  logic          memReq, memReqNext;
  logic          memWe, memWeNext;
  logic [AW-1:0] memAddr, memAddrNext;
  logic [DW-1:0] memWdata, memWdataNext;
  logic [DW-1:0] ifRdata, ifRdataNext;
  logic [DW-1:0] dRdata, dRdataNext;
  logic          ifAck, ifAckNext;
  logic          dAck, dAckNext;

  logic          starveOverride;
  logic          pickI, pickD;

  // Fetch wins only when data is idle or the starvation guard has fired.
  assign pickI = bus.if_req & (~bus.d_req | starveOverride);
  assign pickD = bus.d_req & ~pickI;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uStarveCtr (
    .clk          (clk),
    .rst_n        (rst_n),
    .dGrantWhileI ((state == IDLE) & pickD & bus.if_req),
    .iGrant       ((state == IDLE) & pickI),
    .override     (starveOverride)
  );
`else
  assign starveOverride = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= GNT_NONE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ifRdata  <= '0;
      dRdata   <= '0;
      ifAck    <= 1'b0;
      dAck     <= 1'b0;
    end else begin
      state    <= stateNext;
      grant    <= grantNext;
      memReq   <= memReqNext;
      memWe    <= memWeNext;
      memAddr  <= memAddrNext;
      memWdata <= memWdataNext;
      ifRdata  <= ifRdataNext;
      dRdata   <= dRdataNext;
      ifAck    <= ifAckNext;
      dAck     <= dAckNext;
    end
  end

  always_comb begin
    stateNext    = state;
    grantNext    = grant;
    memReqNext   = memReq;
    memWeNext    = memWe;
    memAddrNext  = memAddr;
    memWdataNext = memWdata;
    ifRdataNext  = ifRdata;
    dRdataNext   = dRdata;
    ifAckNext    = 1'b0;
    dAckNext     = 1'b0;

    case (state)
      IDLE: begin
        if (pickD) begin
          grantNext    = GNT_D;
          memReqNext   = 1'b1;
          memWeNext    = bus.d_we;
          memAddrNext  = bus.d_addr;
          memWdataNext = bus.d_wdata;
          stateNext    = BUSY;
        end else if (pickI) begin
          grantNext    = GNT_I;
          memReqNext   = 1'b1;
          memWeNext    = 1'b0;
          memAddrNext  = bus.if_addr;
          stateNext    = BUSY;
        end
      end
      BUSY: begin
        // Requester req is not consulted here: a dropped req still completes.
        if (bus.mem_ready) begin
          memReqNext = 1'b0;
          memWeNext  = 1'b0;
          stateNext  = RESP;
          if (grant == GNT_I) begin
            ifAckNext   = 1'b1;
            ifRdataNext = bus.mem_rdata;
          end else if (grant == GNT_D) begin
            dAckNext = 1'b1;
            if (!memWe) dRdataNext = bus.mem_rdata;
          end
        end
      end
      RESP: begin
        // Requester still shows the finished access; never re-arbitrate here.
        stateNext = IDLE;
        grantNext = GNT_NONE;
      end
      default: begin
        stateNext = IDLE;
        grantNext = GNT_NONE;
      end
    endcase
  end

  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.if_rdata  = ifRdata;
  assign bus.if_ack    = ifAck;
  assign bus.d_rdata   = dRdata;
  assign bus.d_ack     = dAck;

  assign stall_f = bus.if_req & ~ifAck;
  assign stall_m = bus.d_req & ~dAck;
  assign busy    = (state != IDLE);

endmodule
